cop0_regfile: RTL and testbench

Coprocessor-0 register file and exception-state holder: the stage downstream of the COP0 instruction decoder. It commits MTC0 writes flagged by `write_cop0` and serves MFC0 reads for `REG_SRC_COP0`. It runs the Count/Compare timer and records exception entry and ERET. It produces `epc` for the PC-source mux and an interrupt request for the exception-check logic.

---
 rtl/cop0_regfile.sv | 102 ++++++++++
 tb/tb_cop0_regfile.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cop0_regfile.sv
// cop0_regfile: COP0 registers with Count/Compare timer, exception state and interrupt request
module cop0_regfile #(
    parameter int unsigned COUNT_DIV    = 2,
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [2:0]  wsel,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    input  logic [4:0]  hw_int,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_epc,
    input  logic        exc_bd,
    input  logic        exc_badvaddr_we,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    output logic [31:0] epc,
    output logic        status_exl,
    output logic        int_req
);
    logic [31:0] badvaddr, count, compare, status, cause;
    logic [7:0]  im, ip;
    logic [4:0]  hw_q, exccode, presc;
    logic [1:0]  ip_sw;
    logic        exl, ie, bd, ti, wr, tick, inc, wr_count, wr_compare;

    assign wr         = we & ~exc_valid & ~eret & (wsel == 3'd0);
    assign wr_count   = wr & (waddr == 5'd9);
    assign wr_compare = wr & (waddr == 5'd11);
    assign tick       = presc == 5'(COUNT_DIV - 1);
    assign inc        = tick & ~wr_count;
    assign ip         = {ti, hw_q, ip_sw};
    assign status     = {9'b0, RESET_STATUS[22], 6'b0, im, 6'b0, exl, ie};
    assign cause      = {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};
    assign rdata      = rsel != 3'd0   ? 32'b0    :
                        raddr == 5'd8  ? badvaddr :
                        raddr == 5'd9  ? count    :
                        raddr == 5'd11 ? compare  :
                        raddr == 5'd12 ? status   :
                        raddr == 5'd13 ? cause    :
                        raddr == 5'd14 ? epc      : 32'b0;
    assign status_exl = exl;
    assign int_req    = ie & ~exl & |(ip & im);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            epc      <= '0;
            im       <= RESET_STATUS[15:8];
            exl      <= RESET_STATUS[1];
            ie       <= RESET_STATUS[0];
            bd       <= 1'b0;
            ti       <= 1'b0;
            hw_q     <= '0;
            exccode  <= '0;
            ip_sw    <= '0;
            presc    <= '0;
        end else begin
            hw_q  <= hw_int;
            presc <= (wr_count | tick) ? 5'd0 : presc + 5'd1;
            if (wr_count)
                count <= wdata;
            else if (tick)
                count <= count + 32'd1;
            // a Compare write clears pending even if an increment hits Compare this edge
            if (wr_compare)
                ti <= 1'b0;
            else if (inc && count + 32'd1 == compare)
                ti <= 1'b1;
            if (wr_compare)
                compare <= wdata;
            if (exc_valid) begin
                if (!exl) begin
                    epc <= exc_epc;
                    bd  <= exc_bd;
                end
                exl     <= 1'b1;
                exccode <= exc_code;
                if (exc_badvaddr_we)
                    badvaddr <= exc_badvaddr;
            end else if (eret) begin
                exl <= 1'b0;
            end else if (wr && waddr == 5'd12) begin
                im  <= wdata[15:8];
                exl <= wdata[1];
                ie  <= wdata[0];
            end
            if (wr && waddr == 5'd13)
                ip_sw <= wdata[9:8];
            if (wr && waddr == 5'd14)
                epc <= wdata;
        end
    end
endmodule

// File: tb/tb_cop0_regfile.sv
// tb_cop0_regfile: directed and random checks of cop0_regfile against a transaction-level model
module tb_cop0_regfile;
    localparam int          DIV = 2;
    localparam logic [31:0] RS  = 32'h0040_0000;

    logic        clk = 1'b0, reset;
    logic        we, exc_valid, exc_bd, exc_badvaddr_we, eret, status_exl, int_req;
    logic [4:0]  waddr, raddr, hw_int, exc_code;
    logic [2:0]  wsel, rsel;
    logic [31:0] wdata, rdata, exc_epc, exc_badvaddr, epc;
    int          total = 0, bad = 0;

    logic [31:0] m_count, m_compare, m_epc, m_badv;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [4:0]  m_hw, m_code;
    logic [1:0]  m_ipsw;
    int          m_phase;

    always #5 clk = ~clk;

    cop0_regfile #(.COUNT_DIV(DIV), .RESET_STATUS(RS)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
        .raddr(raddr), .rsel(rsel), .rdata(rdata), .hw_int(hw_int),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .exc_badvaddr_we(exc_badvaddr_we), .exc_badvaddr(exc_badvaddr), .eret(eret),
        .epc(epc), .status_exl(status_exl), .int_req(int_req)
    );

    function automatic logic [7:0] m_ip();
        return {m_ti, m_hw, m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 3'd0) return 32'b0;
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return {9'b0, RS[22], 6'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13:   return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            default: return 32'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0;
        m_im = RS[15:8]; m_exl = RS[1]; m_ie = RS[0];
        m_bd = 0; m_ti = 0; m_hw = 0; m_code = 0; m_ipsw = 0; m_phase = 0;
    endtask

    task automatic idle();
        we = 0; wsel = 0; waddr = 0; wdata = 0;
        exc_valid = 0; exc_code = 0; exc_epc = 0; exc_bd = 0;
        exc_badvaddr_we = 0; exc_badvaddr = 0; eret = 0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare outputs.
    task automatic step();
        logic w, inc;
        logic [31:0] nc;
        @(posedge clk);
        w = we && !exc_valid && !eret && wsel == 3'd0;
        inc = 0;
        nc = m_count;
        if (w && waddr == 5'd9) begin
            nc = wdata;
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase % DIV == 0) begin
                inc = 1;
                nc = m_count + 32'd1;
            end
        end
        if (w && waddr == 5'd11) m_ti = 0;
        else if (inc && nc == m_compare) m_ti = 1;
        m_count = nc;
        if (w && waddr == 5'd11) m_compare = wdata;
        m_hw = hw_int;
        if (exc_valid) begin
            if (!m_exl) begin
                m_epc = exc_epc;
                m_bd = exc_bd;
            end
            m_exl = 1;
            m_code = exc_code;
            if (exc_badvaddr_we) m_badv = exc_badvaddr;
        end else if (eret) begin
            m_exl = 0;
        end else if (w) begin
            if (waddr == 5'd12) begin
                m_im = wdata[15:8];
                m_exl = wdata[1];
                m_ie = wdata[0];
            end
            if (waddr == 5'd13) m_ipsw = wdata[9:8];
            if (waddr == 5'd14) m_epc = wdata;
        end
        #1;
        chk("epc", epc, m_epc);
        chk("status_exl", {31'b0, status_exl}, {31'b0, m_exl});
        chk("int_req", {31'b0, int_req},
            {31'b0, m_ie && !m_exl && ((m_ip() & m_im) != 8'b0)});
        chk("rdata", rdata, m_read(raddr, rsel));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        we = 1; waddr = a; wdata = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        raddr = a; rsel = 0;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        idle();
        hw_int = 0; raddr = 9; rsel = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 0;
        rd(12, "rst_status", 32'h0040_0000);
        rd(13, "rst_cause", 32'h0);
        rd(9, "rst_count", 32'h0);
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_epc", epc, 32'h0);

        wr(12, 32'h0000_8001);
        wr(11, 32'd5);
        wr(9, 32'd3);
        raddr = 13;
        repeat (3) step();
        chk("timer_early", {31'b0, int_req}, 32'h0);
        step();
        chk("timer_int", {31'b0, int_req}, 32'h1);
        chk("timer_ti", {31'b0, rdata[30]}, 32'h1);
        wr(11, 32'd5);
        rd(13, "timer_clear", 32'h0);

        idle();
        exc_valid = 1; exc_code = 5'h04; exc_epc = 32'h8000_0100; exc_bd = 1;
        exc_badvaddr_we = 1; exc_badvaddr = 32'h1234_5677;
        step();
        idle();
        chk("exc_epc", epc, 32'h8000_0100);
        chk("exc_exl", {31'b0, status_exl}, 32'h1);
        rd(13, "exc_cause", 32'h8000_0010);
        rd(8, "exc_badvaddr", 32'h1234_5677);

        exc_valid = 1; exc_code = 5'h0C; exc_epc = 32'h0000_0200;
        step();
        idle();
        chk("nest_epc", epc, 32'h8000_0100);
        rd(13, "nest_cause", 32'h8000_0030);

        eret = 1; we = 1; waddr = 12; wdata = 32'h0;
        step();
        idle();
        chk("eret_exl", {31'b0, status_exl}, 32'h0);
        rd(12, "eret_status", 32'h0040_8001);

        exc_valid = 1; exc_epc = 32'h0000_0300; we = 1; waddr = 14; wdata = 32'hDEAD_BEEF;
        step();
        idle();
        chk("exc_vs_we", epc, 32'h0000_0300);
        eret = 1;
        step();
        wr(8, 32'hFFFF_FFFF);
        rd(8, "badv_ro", 32'h1234_5677);
        idle();
        we = 1; waddr = 14; wsel = 1; wdata = 32'h5555_5555;
        step();
        idle();
        chk("sel1_ignored", epc, 32'h0000_0300);

        hw_int = 5'b00001;
        wr(12, 32'h0000_FF01);
        chk("hw_int_req", {31'b0, int_req}, 32'h1);
        wr(12, 32'h0000_FF03);
        chk("exl_masks", {31'b0, int_req}, 32'h0);
        hw_int = 0;
        wr(12, 32'h0);

        raddr = 9;
        repeat (5) step();
        #2 reset = 1;
        #1;
        chk("async_count", rdata, 32'h0);
        chk("async_epc", epc, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk) reset = 0;
        rd(12, "async_status", 32'h0040_0000);

        for (int i = 0; i < 800; i++) begin
            idle();
            hw_int = 5'($urandom);
            we = ($urandom_range(0, 2) == 0);
            waddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(8, 14));
            wsel = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
            wdata = $urandom;
            if (waddr == 5'd11) wdata = m_count + 32'($urandom_range(0, 4));
            if (waddr == 5'd9) wdata = m_compare - 32'($urandom_range(1, 4));
            exc_valid = ($urandom_range(0, 15) == 0);
            exc_code = 5'($urandom);
            exc_epc = $urandom;
            exc_bd = 1'($urandom);
            exc_badvaddr_we = 1'($urandom);
            exc_badvaddr = $urandom;
            eret = ($urandom_range(0, 7) == 0);
            raddr = 5'($urandom_range(6, 16));
            rsel = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
